// File: rtl/ga_mutate.sv
// ga_mutate: mutation stage of the brew-run GA engine.
// Walks the population one chunk per cycle and flips at most one LFSR-chosen bit per chunk.
//
//  state | meaning
//  IDLE  | waiting for a fresh mut_start
//  LOAD  | capture population, clear flip count and chunk index
//  RUN   | process one chunk per cycle, LFSR advances
//  DONE  | result valid on mut_pop, held until mut_start drops
module ga_mutate #(
    parameter int          POP_W      = 7501,
    parameter int          CHUNK_W    = 32,
    parameter int          MUT_THRESH = 8,
    parameter logic [31:0] SEED       = 32'hACE1_2468,
    parameter int          CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mut_start,
    input  logic [POP_W-1:0] population,
    output logic [POP_W-1:0] mut_pop,
    output logic             mut_done,
    output logic             busy,
    output logic [CNT_W-1:0] flip_count
);

    localparam int NCHUNK     = (POP_W + CHUNK_W - 1) / CHUNK_W;
    localparam int PAD_W      = NCHUNK * CHUNK_W;
    localparam int IDX_W      = (CHUNK_W > 1) ? $clog2(CHUNK_W) : 1;
    localparam int CIDX_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int LAST_VALID = POP_W - (NCHUNK - 1) * CHUNK_W;

    localparam logic [31:0]       SEED_EFF     = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [8:0]        THRESH       = 9'(MUT_THRESH);
    localparam logic [CIDX_W-1:0] LAST_CHUNK   = CIDX_W'(NCHUNK - 1);
    localparam logic [IDX_W:0]    LAST_VALID_L = (IDX_W + 1)'(LAST_VALID);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PAD_W-1:0]   work;
    logic [PAD_W-1:0]   work_rot;
    logic [31:0]        lfsr;
    logic [31:0]        lfsr_nxt;
    logic [CIDX_W-1:0]  chunk;
    logic [7:0]         r_val;
    logic [IDX_W-1:0]   idx;
    logic               last_chunk;
    logic               in_range;
    logic               do_flip;
    logic [CHUNK_W-1:0] flip_mask;
    logic [CHUNK_W-1:0] chunk_new;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a held mut_start parks in DONE so it cannot re-trigger
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (mut_start) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_RUN;
            S_RUN:  if (last_chunk) state_nxt = S_DONE;
            S_DONE: if (!mut_start) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs
    always_comb begin
        busy     = 1'b0;
        mut_done = 1'b0;
        case (state)
            S_LOAD, S_RUN: busy     = 1'b1;
            S_DONE:        mut_done = 1'b1;
            default: ;
        endcase
    end

    assign lfsr_nxt = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};

    // Bit selection for the chunk currently sitting at the bottom of work
    always_comb begin
        r_val      = lfsr[31:24];
        idx        = lfsr[IDX_W-1:0];
        last_chunk = (chunk == LAST_CHUNK);
        in_range   = !last_chunk || ({1'b0, idx} < LAST_VALID_L);
        do_flip    = ({1'b0, r_val} < THRESH) && in_range;
        flip_mask  = do_flip ? (CHUNK_W'(1) << idx) : '0;
        chunk_new  = work[CHUNK_W-1:0] ^ flip_mask;
    end

    // work rotates right one chunk per RUN cycle, so after NCHUNK cycles it is back in place
    generate
        if (NCHUNK > 1) begin : g_rot
            assign work_rot = {chunk_new, work[PAD_W-1:CHUNK_W]};
        end else begin : g_single
            assign work_rot = chunk_new;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work       <= '0;
            mut_pop    <= '0;
            flip_count <= '0;
            lfsr       <= SEED_EFF;
            chunk      <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    work       <= PAD_W'(population);
                    flip_count <= '0;
                    chunk      <= '0;
                end
                S_RUN: begin
                    work  <= work_rot;
                    lfsr  <= lfsr_nxt;
                    chunk <= chunk + CIDX_W'(1);
                    if (do_flip) begin
                        flip_count <= flip_count + CNT_W'(1);
                    end
                    if (last_chunk) begin
                        mut_pop <= work_rot[POP_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ga_mutate.sv
// Bench for ga_mutate: three instances (identity, forced, small config) checked
// against a chunk-walking LFSR model plus hand-computed literals.
module tb_ga_mutate;

    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start [3];
    logic [7500:0]    pin   [3];
    logic             done  [3];
    logic             busy  [3];
    logic [7:0]       cnt   [3];
    logic [7500:0]    pout0;
    logic [7500:0]    pout1;
    logic [39:0]      pout_sm;

    logic [7500:0]    exp_pop [3];
    int               exp_cnt [3];
    logic [31:0]      m_lfsr  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ga_mutate #(.MUT_THRESH(0)) u_id (
        .clk(clk), .rst_n(rst_n), .mut_start(start[0]), .population(pin[0]),
        .mut_pop(pout0), .mut_done(done[0]), .busy(busy[0]), .flip_count(cnt[0])
    );

    ga_mutate #(.MUT_THRESH(256)) u_full (
        .clk(clk), .rst_n(rst_n), .mut_start(start[1]), .population(pin[1]),
        .mut_pop(pout1), .mut_done(done[1]), .busy(busy[1]), .flip_count(cnt[1])
    );

    ga_mutate #(.POP_W(40), .CHUNK_W(8), .MUT_THRESH(128)) u_sm (
        .clk(clk), .rst_n(rst_n), .mut_start(start[2]), .population(pin[2][39:0]),
        .mut_pop(pout_sm), .mut_done(done[2]), .busy(busy[2]), .flip_count(cnt[2])
    );

    function automatic logic [7500:0] pout_of(input int s);
        case (s)
            0:       return pout0;
            1:       return pout1;
            default: return {7461'b0, pout_sm};
        endcase
    endfunction

    function automatic void cfg_of(input int s, output int pw, output int cw, output int th);
        case (s)
            0:       begin pw = 7501; cw = 32; th = 0;   end
            1:       begin pw = 7501; cw = 32; th = 256; end
            default: begin pw = 40;   cw = 8;  th = 128; end
        endcase
    endfunction

    // One complete mutation pass described directly from the chunk rules
    function automatic void model_run(input int s, input logic [31:0] l_in, input logic [7500:0] p,
                                      output logic [31:0] l_out, output logic [7500:0] q,
                                      output int fc);
        int pw, cw, th, nch, r, idx, pos;
        logic [31:0] l;
        cfg_of(s, pw, cw, th);
        nch = (pw + cw - 1) / cw;
        l   = l_in;
        q   = '0;
        fc  = 0;
        for (int i = 0; i < pw; i++) q[i] = p[i];
        for (int k = 0; k < nch; k++) begin
            r   = int'(l[31:24]);
            idx = int'(l % 32'(cw));
            pos = k * cw + idx;
            if (r < th && pos < pw) begin
                q[pos] = ~q[pos];
                fc++;
            end
            l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
        end
        l_out = l;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_true(input string name, input bit cond);
        checks++;
        if (!cond) begin
            errors++;
            $display("FAIL %s actual=false required=true", name);
        end
    endtask

    task automatic chk_wide(input string name, input logic [7500:0] act, input logic [7500:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual_low64=%h required_low64=%h actual_ones=%0d required_ones=%0d",
                     name, act[63:0], req[63:0], $countones(act), $countones(req));
        end
    endtask

    // Whenever a result is presented it must match the model's prediction
    always @(negedge clk) begin
        if (rst_n) begin
            for (int s = 0; s < 3; s++) begin
                if (done[s]) begin
                    chk_wide($sformatf("model_pop_%0d", s), pout_of(s), exp_pop[s]);
                    chk($sformatf("model_count_%0d", s), longint'(cnt[s]), longint'(exp_cnt[s]));
                end
            end
        end
    end

    task automatic run(input int s, input logic [7500:0] p, input bit disturb);
        int lat;
        int want;
        @(negedge clk);
        pin[s]   = p;
        start[s] = 1'b1;
        @(posedge clk);
        model_run(s, m_lfsr[s], p, m_lfsr[s], exp_pop[s], exp_cnt[s]);
        lat = 0;
        while (lat < 1000) begin
            @(posedge clk);
            lat++;
            #1;
            if (disturb) begin
                if (lat >= 5 && lat < 15) begin
                    start[s] = lat[0];
                    pin[s]   = ~p;
                end
                if (lat == 20) start[s] = 1'b1;
            end
            if (done[s]) break;
        end
        want = (s == 2) ? 6 : 236;
        chk($sformatf("latency_%0d", s), longint'(lat), longint'(want));
    endtask

    task automatic release_start(input int s);
        @(negedge clk);
        start[s] = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("done_fall_%0d", s), longint'(done[s]), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            start[s]  = 1'b0;
            m_lfsr[s] = SEED;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7500:0] ones;
        logic [7500:0] hp;
        logic [7500:0] first_pop;
        logic [7500:0] h1;
        logic [7500:0] undist;
        int            undist_cnt;
        int            pc, maxc, c, bad;

        ones = '1;
        hp   = 7501'({235{32'h5A5A_0F0F}});
        for (int s = 0; s < 3; s++) begin
            start[s]  = 1'b0;
            pin[s]    = '0;
            m_lfsr[s] = SEED;
        end

        #12;
        for (int s = 0; s < 3; s++) begin
            chk_wide($sformatf("reset_pop_%0d", s), pout_of(s), '0);
            chk($sformatf("reset_done_%0d", s), longint'(done[s]), 0);
            chk($sformatf("reset_busy_%0d", s), longint'(busy[s]), 0);
            chk($sformatf("reset_count_%0d", s), longint'(cnt[s]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Identity: threshold 0 never flips
        run(0, ones, 1'b0);
        chk_wide("identity_all_ones", pout0, ones);
        chk("identity_count", longint'(cnt[0]), 0);
        release_start(0);

        // Forced: chunk0 idx=8 (seed low byte 0x68), chunk1 idx=16 (next lfsr 0x59C248D0)
        run(1, '0, 1'b0);
        first_pop = pout1;
        chk("forced_low64", longint'(pout1[63:0]), longint'(64'h0001_0000_0000_0100));
        pc   = 0;
        maxc = 0;
        for (int k = 0; k < 235; k++) begin
            c = 0;
            for (int b = 0; b < 32; b++) begin
                if (k * 32 + b < 7501 && pout1[k * 32 + b]) c++;
            end
            pc += c;
            if (c > maxc) maxc = c;
        end
        chk("forced_popcount_vs_count", longint'(pc), longint'(cnt[1]));
        chk_true("forced_count_in_222_235", cnt[1] >= 8'd222 && cnt[1] <= 8'd235);
        chk_true("forced_max_one_per_chunk", maxc <= 1);
        release_start(1);

        // Small config: only chunks 1 (bit 8) and 3 (bit 25) pass the 128 threshold first time
        run(2, '0, 1'b0);
        chk("small_first_literal", longint'(pout_sm), longint'(40'h00_0200_0100));
        chk("small_first_count", longint'(cnt[2]), 2);
        release_start(2);
        for (int n = 0; n < 50; n++) begin
            run(2, 7501'({$urandom, $urandom}), 1'b0);
            release_start(2);
        end

        // Handshake: held start gives one run only
        run(1, hp, 1'b0);
        h1  = pout1;
        bad = 0;
        repeat (400 - 237) begin
            @(posedge clk);
            #1;
            if (!done[1] || busy[1]) bad++;
        end
        chk("handshake_held_bad_cycles", longint'(bad), 0);
        release_start(1);
        run(1, hp, 1'b0);
        chk_true("handshake_rerun_differs", pout1 != h1);
        release_start(1);

        // Reset in the middle of RUN
        @(negedge clk);
        pin[1]   = '0;
        start[1] = 1'b1;
        @(posedge clk);
        repeat (101) @(posedge clk);
        #1;
        chk("midrun_busy_before_reset", longint'(busy[1]), 1);
        #1;
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            start[s]  = 1'b0;
            m_lfsr[s] = SEED;
        end
        #1;
        chk_wide("midrun_reset_pop", pout1, '0);
        chk("midrun_reset_done", longint'(done[1]), 0);
        chk("midrun_reset_busy", longint'(busy[1]), 0);
        chk("midrun_reset_count", longint'(cnt[1]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(1, '0, 1'b0);
        chk_wide("reset_rerun_matches_first", pout1, first_pop);
        release_start(1);

        // Disturbed inputs during RUN must not change the result
        do_reset();
        run(1, hp, 1'b0);
        undist     = pout1;
        undist_cnt = int'(cnt[1]);
        release_start(1);
        do_reset();
        run(1, hp, 1'b1);
        chk_wide("disturbed_pop_matches", pout1, undist);
        chk("disturbed_count_matches", longint'(cnt[1]), longint'(undist_cnt));
        release_start(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ga_mutate.md
Name: ga_mutate

Overview:
- Mutation stage of the genetic brew-run engine.
- Sits directly downstream of the State controller. It consumes the population bus and the mut_start handshake, and returns mut_pop / mut_done to the controller.
- Walks the population one CHUNK_W-bit chunk per cycle. It flips at most one pseudo-random bit per chunk, gated by a programmable probability, using an internal 32-bit LFSR.

Parameters:
- POP_W, 7501: population width in bits.
- CHUNK_W, 32: bits examined per cycle; power of two, 2..32.
- MUT_THRESH, 8: mutation probability per chunk is MUT_THRESH/256. Legal range 0..256; 256 means always flip.
- SEED, 32'hACE1_2468: LFSR reset value. A value of 0 is replaced by 1.
- CNT_W, 8: flip_count width; must hold ceil(POP_W/CHUNK_W).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mut_start  input  1  level request from State.
- population  input  POP_W  current population; sampled only on accept.
- mut_pop  output  POP_W  mutated population; registered.
- mut_done  output  1  level completion flag.
- busy  output  1  high in LOAD/RUN.
- flip_count  output  CNT_W  number of bits flipped in the last run.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; mut_pop=0, mut_done=0, busy=0, flip_count=0.
  - lfsr=SEED (or 1 if SEED is 0); chunk index=0.
  - Reset mid-run aborts the run with no partial result retained.
- NCHUNK = ceil(POP_W/CHUNK_W). With defaults this is 235; the last chunk holds 13 valid bits.
- LFSR: Fibonacci, shifts left each RUN cycle. New bit 0 = l[31]^l[21]^l[1]^l[0]. Advances only in RUN and keeps running across runs; it is never reseeded except by reset.
- Per RUN cycle k (chunk k):
  - r = lfsr[31:24]; idx = lfsr[log2(CHUNK_W)-1:0]; both are taken from the pre-advance value.
  - Flip work bit k*CHUNK_W+idx iff r < MUT_THRESH AND that bit index < POP_W.
  - On a flip, flip_count increments by 1.
- States:
  - IDLE: mut_done=0. mut_start=1 -> LOAD.
  - LOAD (1 cycle): work register <= population; flip_count<=0; chunk<=0; busy=1 -> RUN.
  - RUN (NCHUNK cycles): process chunk k, then k++. After chunk NCHUNK-1: mut_pop <= work incl. the final flip; then -> DONE.
  - DONE: mut_done=1, busy=0; mut_pop and flip_count held. mut_start=0 -> IDLE (mut_done falls on that edge).
- Latency: mut_start sampled high in IDLE at edge E0 -> mut_done high after edge E0+NCHUNK+1. With defaults, 236 cycles.
- Handshake:
  - Level-based, matching the controller: mut_done stays high as long as mut_start is held.
  - A new run requires mut_start low, then high again. A mut_start held high never re-triggers.
- mut_start changes during LOAD/RUN are ignored; deassertion does not abort.
- population changes after LOAD have no effect.
- mut_pop is only updated at end of RUN, so it never shows partial results.
- MUT_THRESH=0: output equals input. MUT_THRESH=256: exactly one flip per chunk whose idx is in range.

Test Plan:
- Identity: MUT_THRESH=0, population all ones, pulse mut_start. Required:
  - mut_done rises exactly 236 cycles after the accept edge.
  - mut_pop all ones; flip_count=0.
- Forced mutation: MUT_THRESH=256, population=0. Required:
  - popcount(mut_pop)==flip_count, and flip_count is in 222..235.
  - Each 32-bit chunk has at most 1 bit set; no bit index ≥7501 is set.
  - The result matches the bench LFSR model bit-exact.
- Handshake: hold mut_start high for 400 cycles. Required:
  - mut_done rises once and stays high; there is no second run (busy stays 0).
  - Drop mut_start -> mut_done=0 next edge.
  - Reassert mut_start -> a second run whose mut_pop differs from the first (LFSR continued).
- Reset mid-run: assert rst_n=0 at cycle 100 of RUN. Required:
  - mut_pop=0, mut_done=0, busy=0 immediately (asynchronous).
  - Rerun with the same input gives a result identical to the first run after power-on.
- Ignored inputs: toggle mut_start and change population during RUN. Required: the result equals the undisturbed run.
- Small config, POP_W=40, CHUNK_W=8, MUT_THRESH=128, 50 random populations. Required:
  - Scoreboard match against the bench LFSR model.
  - mut_done at 6 cycles after accept.
